// File: rtl/bfly_output_arbiter.sv
// bfly_output_arbiter
// Merges the two butterfly serial ports (A = real, B = complex) onto the HBM
// write channels. Each channel is independent and has its own pair of source
// FIFOs, a registered output stage and a round-robin pointer choosing A or B.
//
// Ports
//   sys_clk         single clock for all logic
//   rst_n           synchronous active-low reset
//   up_vld_A/B      per-channel beat valid from port A / B
//   up_dat_A/B      port beats, channel i at [DATA_WIDTH_AXI*i +: DATA_WIDTH_AXI]
//   up_rdy_A/B      per-channel ready (FIFO not full), held low during reset
//   dn_vld/dat/src  per-channel HBM write beat, src 0 = A, 1 = B
//   dn_rdy          per-channel HBM write ready
//   idle            all FIFOs empty and no output beat pending
module bfly_output_arbiter #(
    parameter int OUTPUT_AXI_CHNL = 8,
    parameter int DATA_WIDTH_AXI  = 256,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                      sys_clk,
    input  logic                                      rst_n,
    input  logic [OUTPUT_AXI_CHNL-1:0]                up_vld_A,
    input  logic [OUTPUT_AXI_CHNL*DATA_WIDTH_AXI-1:0] up_dat_A,
    output logic [OUTPUT_AXI_CHNL-1:0]                up_rdy_A,
    input  logic [OUTPUT_AXI_CHNL-1:0]                up_vld_B,
    input  logic [OUTPUT_AXI_CHNL*DATA_WIDTH_AXI-1:0] up_dat_B,
    output logic [OUTPUT_AXI_CHNL-1:0]                up_rdy_B,
    output logic [OUTPUT_AXI_CHNL-1:0]                dn_vld,
    output logic [OUTPUT_AXI_CHNL*DATA_WIDTH_AXI-1:0] dn_dat,
    output logic [OUTPUT_AXI_CHNL-1:0]                dn_src,
    input  logic [OUTPUT_AXI_CHNL-1:0]                dn_rdy,
    output logic                                      idle
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

    logic [OUTPUT_AXI_CHNL-1:0] busy;

    assign idle = ~|busy;

    genvar i;
    generate
        for (i = 0; i < OUTPUT_AXI_CHNL; i++) begin : g_chnl
            logic [DATA_WIDTH_AXI-1:0] mem_a [FIFO_DEPTH];
            logic [DATA_WIDTH_AXI-1:0] mem_b [FIFO_DEPTH];
            logic [PW-1:0]             wr_a, rd_a, wr_b, rd_b;
            logic [CW-1:0]             cnt_a, cnt_b;
            logic                      ne_a, ne_b, rdy_a, rdy_b;
            logic                      push_a, push_b, pop_a, pop_b;
            logic                      load, any, gnt_b, rr;
            logic                      out_vld, out_src;
            logic [DATA_WIDTH_AXI-1:0] out_dat;

            assign ne_a = (cnt_a != '0);
            assign ne_b = (cnt_b != '0);
            // Ready comes only from registered occupancy, never from dn_rdy.
            assign rdy_a = rst_n && (cnt_a != C_FULL);
            assign rdy_b = rst_n && (cnt_b != C_FULL);
            assign push_a = up_vld_A[i] && rdy_a;
            assign push_b = up_vld_B[i] && rdy_b;

            always_comb begin
                load  = !out_vld || dn_rdy[i];
                any   = ne_a || ne_b;
                // rr = 0 prefers A; a lone non-empty FIFO always wins.
                gnt_b = (ne_a && ne_b) ? rr : ne_b;
                pop_a = load && any && !gnt_b;
                pop_b = load && any && gnt_b;
            end

            always_ff @(posedge sys_clk) begin
                if (push_a) mem_a[wr_a] <= up_dat_A[DATA_WIDTH_AXI*i +: DATA_WIDTH_AXI];
                if (push_b) mem_b[wr_b] <= up_dat_B[DATA_WIDTH_AXI*i +: DATA_WIDTH_AXI];
            end

            always_ff @(posedge sys_clk) begin
                if (!rst_n) begin
                    wr_a    <= '0;
                    rd_a    <= '0;
                    cnt_a   <= '0;
                    wr_b    <= '0;
                    rd_b    <= '0;
                    cnt_b   <= '0;
                    rr      <= 1'b0;
                    out_vld <= 1'b0;
                    out_src <= 1'b0;
                    out_dat <= '0;
                end else begin
                    if (push_a) wr_a <= wr_a + P_ONE;
                    if (pop_a)  rd_a <= rd_a + P_ONE;
                    if (push_b) wr_b <= wr_b + P_ONE;
                    if (pop_b)  rd_b <= rd_b + P_ONE;

                    case ({push_a, pop_a})
                        2'b10:   cnt_a <= cnt_a + C_ONE;
                        2'b01:   cnt_a <= cnt_a - C_ONE;
                        default: cnt_a <= cnt_a;
                    endcase
                    case ({push_b, pop_b})
                        2'b10:   cnt_b <= cnt_b + C_ONE;
                        2'b01:   cnt_b <= cnt_b - C_ONE;
                        default: cnt_b <= cnt_b;
                    endcase

                    if (load) begin
                        if (any) begin
                            out_vld <= 1'b1;
                            out_src <= gnt_b;
                            out_dat <= gnt_b ? mem_b[rd_b] : mem_a[rd_a];
                            rr      <= !gnt_b;
                        end else begin
                            out_vld <= 1'b0;
                        end
                    end
                end
            end

            assign up_rdy_A[i] = rdy_a;
            assign up_rdy_B[i] = rdy_b;
            assign dn_vld[i]   = out_vld;
            assign dn_src[i]   = out_src;
            assign dn_dat[DATA_WIDTH_AXI*i +: DATA_WIDTH_AXI] = out_dat;
            assign busy[i]     = out_vld || ne_a || ne_b;
        end
    endgenerate

endmodule

// File: tb/tb_bfly_output_arbiter.sv
module tb_bfly_output_arbiter;

    localparam int N = 8;
    localparam int W = 256;
    localparam int D = 4;

    typedef logic [W-1:0] beat_t;

    logic             sys_clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     up_vld_A, up_rdy_A, up_vld_B, up_rdy_B;
    logic [N*W-1:0]   up_dat_A, up_dat_B, dn_dat;
    logic [N-1:0]     dn_vld, dn_src, dn_rdy;
    logic             idle;

    int checks = 0;
    int errors = 0;

    bfly_output_arbiter #(.OUTPUT_AXI_CHNL(N), .DATA_WIDTH_AXI(W), .FIFO_DEPTH(D)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .up_vld_A(up_vld_A), .up_dat_A(up_dat_A), .up_rdy_A(up_rdy_A),
        .up_vld_B(up_vld_B), .up_dat_B(up_dat_B), .up_rdy_B(up_rdy_B),
        .dn_vld(dn_vld), .dn_dat(dn_dat), .dn_src(dn_src), .dn_rdy(dn_rdy),
        .idle(idle)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    beat_t q_a [N][$];
    beat_t q_b [N][$];
    bit    m_vld [N];
    bit    m_src [N];
    beat_t m_dat [N];
    bit    m_pref_b [N];
    int    total_in = 0;
    int    total_out = 0;

    always @(posedge sys_clk) begin
        if (!rst_n) begin
            for (int c = 0; c < N; c++) begin
                q_a[c].delete();
                q_b[c].delete();
                m_vld[c] = 0; m_src[c] = 0; m_dat[c] = '0; m_pref_b[c] = 0;
            end
            total_in = 0;
            total_out = 0;
        end else begin
            for (int c = 0; c < N; c++) begin
                bit acc_a, acc_b, take_b;
                if (dn_vld[c] && dn_rdy[c]) total_out++;
                acc_a = up_vld_A[c] && (q_a[c].size() < D);
                acc_b = up_vld_B[c] && (q_b[c].size() < D);
                if (!m_vld[c] || dn_rdy[c]) begin
                    if (q_a[c].size() > 0 || q_b[c].size() > 0) begin
                        if (q_a[c].size() > 0 && q_b[c].size() > 0) take_b = m_pref_b[c];
                        else take_b = (q_b[c].size() > 0);
                        m_dat[c] = take_b ? q_b[c].pop_front() : q_a[c].pop_front();
                        m_src[c] = take_b;
                        m_vld[c] = 1;
                        m_pref_b[c] = !take_b;
                    end else begin
                        m_vld[c] = 0;
                    end
                end
                if (acc_a) begin q_a[c].push_back(up_dat_A[c*W +: W]); total_in++; end
                if (acc_b) begin q_b[c].push_back(up_dat_B[c*W +: W]); total_in++; end
            end
        end
    end

    always @(negedge sys_clk) begin
        logic [N-1:0]   e_ra, e_rb, e_vld, e_src;
        logic [N*W-1:0] e_dat;
        logic           e_idle;
        e_idle = 1'b1;
        for (int c = 0; c < N; c++) begin
            e_ra[c]  = rst_n && (q_a[c].size() < D);
            e_rb[c]  = rst_n && (q_b[c].size() < D);
            e_vld[c] = m_vld[c];
            e_src[c] = m_src[c];
            e_dat[c*W +: W] = m_dat[c];
            if (m_vld[c] || q_a[c].size() > 0 || q_b[c].size() > 0) e_idle = 1'b0;
        end
        chk("mdl_rdy_A", W'(up_rdy_A), W'(e_ra));
        chk("mdl_rdy_B", W'(up_rdy_B), W'(e_rb));
        chk("mdl_dn_vld", W'(dn_vld), W'(e_vld));
        chk("mdl_dn_src", W'(dn_src), W'(e_src));
        chk("mdl_idle", W'(idle), W'(e_idle));
        for (int c = 0; c < N; c++) chk("mdl_dn_dat", dn_dat[c*W +: W], e_dat[c*W +: W]);
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        int          ch;
        bit          av;
        logic [31:0] ad;
        bit          bv;
        logic [31:0] bd;
        bit          rdy;
        bit          ev;
        logic [31:0] ed;
        bit          es;
    } vec_t;

    vec_t tbl [$];

    task automatic clear_inputs();
        up_vld_A = '0; up_vld_B = '0; up_dat_A = '0; up_dat_B = '0;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int    acc;
        bit    was;
        beat_t held;

        rst_n = 1'b0;
        clear_inputs();
        dn_rdy = '1;

        // single beat on ch0, A only
        tbl.push_back('{0, 1, 32'h11, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 1, 32'h11, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 0});
        // ch3, both ports streaming: 1,10,2,20,3,30
        tbl.push_back('{3, 1, 1, 1, 10, 1, 0, 0, 0});
        tbl.push_back('{3, 1, 2, 1, 20, 1, 1, 1, 0});
        tbl.push_back('{3, 1, 3, 1, 30, 1, 1, 10, 1});
        tbl.push_back('{3, 0, 0, 0, 0, 1, 1, 2, 0});
        tbl.push_back('{3, 0, 0, 0, 0, 1, 1, 20, 1});
        tbl.push_back('{3, 0, 0, 0, 0, 1, 1, 3, 0});
        tbl.push_back('{3, 0, 0, 0, 0, 1, 1, 30, 1});
        tbl.push_back('{3, 0, 0, 0, 0, 1, 0, 0, 0});

        repeat (3) tick();
        chk("rst_rdy_A_low", W'(up_rdy_A), W'(0));
        rst_n = 1'b1;
        #1;
        chk("rel_rdy_A", W'(up_rdy_A), W'({N{1'b1}}));
        chk("rel_rdy_B", W'(up_rdy_B), W'({N{1'b1}}));
        chk("rel_dn_vld", W'(dn_vld), W'(0));
        chk("rel_idle", W'(idle), W'(1));
        chk("rel_dn_dat", dn_dat[W-1:0], W'(0));

        foreach (tbl[v]) begin
            clear_inputs();
            up_vld_A[tbl[v].ch] = tbl[v].av;
            up_dat_A[tbl[v].ch*W +: W] = W'(tbl[v].ad);
            up_vld_B[tbl[v].ch] = tbl[v].bv;
            up_dat_B[tbl[v].ch*W +: W] = W'(tbl[v].bd);
            dn_rdy = {N{tbl[v].rdy}};
            tick();
            chk("tbl_vld", W'(dn_vld[tbl[v].ch]), W'(tbl[v].ev));
            chk("tbl_other_vld", W'(dn_vld & ~(N'(1) << tbl[v].ch)), W'(0));
            if (tbl[v].ev) begin
                chk("tbl_dat", dn_dat[tbl[v].ch*W +: W], W'(tbl[v].ad === 'x ? 0 : tbl[v].ed));
                chk("tbl_src", W'(dn_src[tbl[v].ch]), W'(tbl[v].es));
            end
        end

        // ch1 backpressure: fill until ready drops
        clear_inputs();
        dn_rdy = '0;
        acc = 0;
        held = '0;
        for (int k = 0; k < 9; k++) begin
            up_vld_A[1] = 1'b1;
            up_dat_A[1*W +: W] = W'(32'h100 + acc);
            was = up_rdy_A[1];
            tick();
            if (was) acc++;
            if (k == 1) held = dn_dat[1*W +: W];
        end
        chk("bp_accepted", W'(acc), W'(D + 1));
        chk("bp_rdy_low", W'(up_rdy_A[1]), W'(0));
        chk("bp_held_vld", W'(dn_vld[1]), W'(1));
        chk("bp_held_dat", dn_dat[1*W +: W], W'(32'h100));
        chk("bp_dat_stable", dn_dat[1*W +: W], held);
        clear_inputs();
        dn_rdy = '1;
        for (int j = 1; j <= D; j++) begin
            tick();
            chk("bp_drain_vld", W'(dn_vld[1]), W'(1));
            chk("bp_drain_dat", dn_dat[1*W +: W], W'(32'h100 + j));
        end
        tick();
        chk("bp_drain_done", W'(dn_vld[1]), W'(0));

        // ch2 reset with beats buffered
        dn_rdy = '0;
        for (int k = 0; k < 3; k++) begin
            clear_inputs();
            up_vld_B[2] = 1'b1;
            up_dat_B[2*W +: W] = W'(32'h200 + k);
            tick();
        end
        clear_inputs();
        tick();
        chk("mr_pre_vld", W'(dn_vld[2]), W'(1));
        chk("mr_pre_idle", W'(idle), W'(0));
        rst_n = 1'b0;
        tick();
        chk("mr_vld", W'(dn_vld), W'(0));
        chk("mr_idle", W'(idle), W'(1));
        chk("mr_rdy_B_low", W'(up_rdy_B), W'(0));
        rst_n = 1'b1;
        dn_rdy = '1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("mr_no_stale", W'(dn_vld), W'(0));
        end

        // random traffic on all channels
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                up_vld_A[c] = ($urandom_range(0, 3) != 0);
                up_vld_B[c] = ($urandom_range(0, 2) == 0);
                dn_rdy[c]   = ($urandom_range(0, 3) != 0);
                for (int w = 0; w < W / 32; w++) begin
                    up_dat_A[c*W + w*32 +: 32] = $urandom;
                    up_dat_B[c*W + w*32 +: 32] = $urandom;
                end
            end
            tick();
        end

        clear_inputs();
        dn_rdy = '1;
        acc = 0;
        while (!idle && acc < 64) begin
            tick();
            acc++;
        end
        chk("drain_idle", W'(idle), W'(1));
        chk("beats_in_eq_out", W'(total_out), W'(total_in));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
